// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit with a fixed-latency busy window and mthi/mtlo moves.
// Divide support (div/divu) is compiled in only when MD_UNIT_DIV_EN is defined.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_A,
    input  logic [31:0] src_B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int DATA_W = 32;
    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MD_UNIT_DIV_EN
    localparam logic [3:0] DIV_LD   = 4'(DIV_CYCLES);
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_mult_range
        $error("MULT_CYCLES must be in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_div_range
        $error("DIV_CYCLES must be in 1..15");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                uns_p0;
    logic [DATA_W-1:0]   a_p0;
    logic [DATA_W-1:0]   b_p0;
`ifdef MD_UNIT_DIV_EN
    logic                div_p0;
`endif
    logic [2*DATA_W-1:0] res_p0;
    logic                wr_ok;

    // Sign- or zero-extend to 64 bits so one multiplier serves both mult and multu.
    function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input logic              sgn);
        logic signed [2*DATA_W-1:0] ea;
        logic signed [2*DATA_W-1:0] eb;
        logic signed [2*DATA_W-1:0] p;
        ea = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        eb = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        p  = ea * eb;
        return p;
    endfunction

`ifdef MD_UNIT_DIV_EN
    // Divide magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
    function automatic logic [2*DATA_W-1:0] div_full(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input logic              sgn);
        logic              na;
        logic              nb;
        logic [DATA_W-1:0] ua;
        logic [DATA_W-1:0] ub;
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        na = sgn & a[DATA_W-1];
        nb = sgn & b[DATA_W-1];
        ua = na ? -a : a;
        ub = nb ? -b : b;
        q  = ua / ub;
        r  = ua % ub;
        if (na ^ nb) q = -q;
        if (na)      r = -r;
        return {r, q};
    endfunction
`endif

    always_comb begin
        res_p0 = mul_full(a_p0, b_p0, !uns_p0);
        wr_ok  = 1'b1;
`ifdef MD_UNIT_DIV_EN
        if (div_p0) begin
            res_p0 = div_full(a_p0, b_p0, !uns_p0);
            wr_ok  = (b_p0 != '0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                state  <= BUSY;
                                busy   <= 1'b1;
                                cnt    <= MULT_LD;
                                uns_p0 <= md_op[0];
`ifdef MD_UNIT_DIV_EN
                                div_p0 <= 1'b0;
`endif
                                a_p0   <= src_A;
                                b_p0   <= src_B;
                            end
`ifdef MD_UNIT_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                state  <= BUSY;
                                busy   <= 1'b1;
                                cnt    <= DIV_LD;
                                uns_p0 <= md_op[0];
                                div_p0 <= 1'b1;
                                a_p0   <= src_A;
                                b_p0   <= src_B;
                            end
`endif
                            OP_MTHI: hi <= src_A;
                            OP_MTLO: lo <= src_A;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // Result lands on the same edge that busy falls.
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (wr_ok) {hi, lo} <= res_p0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, number of busy cycles for mult/multu (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, number of busy cycles for div/divu (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to issue md_op this cycle.
REQ-006 SHALL have port md_op  input  3  operation code:
- 000 mult
- 001 multu
- 010 div
- 011 divu
- 100 mthi
- 101 mtlo
- 110/111 reserved
REQ-007 SHALL have port src_A  input  32  first operand; dividend; mthi/mtlo source.
REQ-008 SHALL have port src_B  input  32  second operand; divisor.
REQ-009 SHALL have port busy  output  1  registered; unit occupied by a multi-cycle operation.
REQ-010 SHALL have port hi  output  32  registered HI register.
REQ-011 SHALL have port lo  output  32  registered LO register.

Function
REQ-012 SHALL implement two states:
- IDLE: IDLE->BUSY on accepted mult/multu/div/divu.
- BUSY: BUSY->IDLE when the cycle counter expires.
REQ-013 SHALL accept start only in IDLE; start in BUSY (any md_op, including mthi/mtlo) SHALL be ignored with no state change.
REQ-014 SHALL, on acceptance, latch md_op, src_A and src_B and load the counter with MULT_CYCLES or DIV_CYCLES; later operand changes SHALL have no effect.
REQ-015 SHALL sequence timing as follows, for an operation accepted at rising edge e0:
- busy=1 for exactly N cycles after e0.
- hi/lo SHALL update at edge e0+N, the same edge at which busy falls.
- hi/lo SHALL hold their prior values throughout BUSY.
REQ-016 SHALL compute mult/multu as the full 64-bit product of the latched operands, signed or unsigned respectively, with {hi,lo} = product.
REQ-017 SHALL compute div/divu as follows:
- lo = quotient, hi = remainder.
- div is signed, quotient truncates toward zero, remainder takes the sign of the dividend.
- divu is unsigned.
REQ-018 SHALL, for div or divu with divisor 0, still stay busy for DIV_CYCLES and leave hi/lo unchanged.
REQ-019 SHALL, for div 0x80000000 / 0xFFFFFFFF, give lo=0x80000000 and hi=0x00000000.
REQ-020 SHALL complete mthi/mtlo accepted in IDLE in one edge: hi (resp. lo) = src_A, the other register unchanged, busy stays 0.
REQ-021 SHALL ignore reserved md_op codes with no state change.
REQ-022 SHALL allow a new start in the first IDLE cycle after busy falls, giving back-to-back operations with zero bubble beyond that cycle.

Reset
REQ-023 SHALL, when reset is high at a rising edge, force state IDLE, busy=0, hi=0x00000000, lo=0x00000000 and counter 0; reset SHALL take priority over start.
REQ-024 SHALL abort any in-flight operation on reset mid-operation, with no hi/lo write ever occurring from the aborted operation.

Configuration
REQ-025 SHALL compile div/divu support only when macro MD_UNIT_DIV_EN is defined; in that case behaviour is as in REQ-017..REQ-019.
REQ-026 SHALL, without MD_UNIT_DIV_EN, treat codes 010/011 as reserved per REQ-021 and instantiate no divider logic; DIV_CYCLES is then unused.

Verification
REQ-027 SHALL cover signed multiply: reset; mult src_A=0xFFFFFFFF, src_B=0x00000002 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-028 SHALL cover unsigned multiply: multu src_A=0xFFFFFFFF, src_B=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-029 SHALL cover signed divide (MD_UNIT_DIV_EN defined): div src_A=0xFFFFFFF9 (-7), src_B=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-030 SHALL cover divide by zero and hi/lo moves: mthi 0x12345678, mtlo 0x9ABCDEF0, then divu by 0 -> busy 10 cycles, hi=0x12345678, lo=0x9ABCDEF0 unchanged.
REQ-031 SHALL cover start while busy: mult 3*4 then start mtlo 0xDEADBEEF on busy cycle 2 -> mtlo ignored; final hi=0, lo=0x0000000C; new start accepted the cycle after busy falls.
REQ-032 SHALL cover reset mid-operation: multu 0xFFFFFFFF*0xFFFFFFFF with reset asserted on busy cycle 3 -> next cycle busy=0, hi=lo=0; no later write.
